// File: rtl/sdi_trs_detector_pkg.sv
// ---------------------------------------------------------------------------
// sdi_trs_detector_pkg
// Shared definitions for the SDI TRS detector:
//   - TRS preamble word values (3FF 000 000 precedes every XYZ word)
//   - detector state encoding
//   - XYZ protection-bit check helper
// ---------------------------------------------------------------------------
package sdi_trs_detector_pkg;

  localparam logic [9:0] TRS_PRE0 = 10'h3FF;
  localparam logic [9:0] TRS_PRE1 = 10'h000;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } trs_state_e;

  // XYZ layout: b9=1, b8=F, b7=V, b6=H, b5..b2 = protection, b1:0 = 00.
  function automatic logic xyz_prot_ok(input logic [9:0] w);
    logic f;
    logic v;
    logic h;
    f = w[8];
    v = w[7];
    h = w[6];
    return (w[9] == 1'b1) && (w[1:0] == 2'b00) &&
           (w[5] == (v ^ h)) && (w[4] == (f ^ h)) &&
           (w[3] == (f ^ v)) && (w[2] == (f ^ v ^ h));
  endfunction

endpackage

// File: rtl/sdi_trs_detector_xyz_decode.sv
// ---------------------------------------------------------------------------
// sdi_trs_detector_xyz_decode
// Keeps a 3-deep history of valid words; the word following 3FF 000 000 is
// the XYZ word, whose protection bits are checked here. All outputs are
// registered (one cycle after the word is accepted).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           restart: drops the word of this cycle, clears the history
//   data, valid   word stream and qualifier
//   vld           registered copy of valid (word was processed last cycle)
//   is_eav/is_sav valid XYZ with H=1 / H=0 (1-cycle pulses)
//   xyz_err       preamble seen but XYZ protection wrong (1-cycle pulse)
//   f, v          F and V bits of the last valid XYZ
// ---------------------------------------------------------------------------
module sdi_trs_detector_xyz_decode
  import sdi_trs_detector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [9:0] data,
  input  logic       valid,
  output logic       vld,
  output logic       is_eav,
  output logic       is_sav,
  output logic       xyz_err,
  output logic       f,
  output logic       v
);

  logic [2:0][9:0] hist_r;   // [2] oldest, [0] newest
  logic            pre_s;
  logic            ok_s;
  logic            vld_r;
  logic            eav_r;
  logic            sav_r;
  logic            err_r;
  logic            f_r;
  logic            v_r;

  assign pre_s = (hist_r[2] == TRS_PRE0) && (hist_r[1] == TRS_PRE1) &&
                 (hist_r[0] == TRS_PRE1);
  assign ok_s  = xyz_prot_ok(data);

  // History shift register and registered decode results.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= '0;
      vld_r  <= 1'b0;
      eav_r  <= 1'b0;
      sav_r  <= 1'b0;
      err_r  <= 1'b0;
      f_r    <= 1'b0;
      v_r    <= 1'b0;
    end else if (clr) begin
      // F/V keep the last accepted XYZ; only the search context is dropped.
      hist_r <= '0;
      vld_r  <= 1'b0;
      eav_r  <= 1'b0;
      sav_r  <= 1'b0;
      err_r  <= 1'b0;
    end else if (valid) begin
      hist_r <= {hist_r[1:0], data};
      vld_r  <= 1'b1;
      eav_r  <= pre_s && ok_s && data[6];
      sav_r  <= pre_s && ok_s && !data[6];
      err_r  <= pre_s && !ok_s;
      if (pre_s && ok_s) begin
        f_r <= data[8];
        v_r <= data[7];
      end
    end else begin
      vld_r <= 1'b0;
      eav_r <= 1'b0;
      sav_r <= 1'b0;
      err_r <= 1'b0;
    end
  end

  assign vld     = vld_r;
  assign is_eav  = eav_r;
  assign is_sav  = sav_r;
  assign xyz_err = err_r;
  assign f       = f_r;
  assign v       = v_r;

endmodule

// File: rtl/sdi_trs_detector.sv
// ---------------------------------------------------------------------------
// sdi_trs_detector
// Finds TRS sequences in a word-aligned 10-bit SDI stream, checks EAV-to-EAV
// spacing and reports lock. n_align_o asks the aligner to slip; the aligner
// restarts the search with detector_rst_i.
// Ports:
//   sys_clk, rst     clock, synchronous active-high reset
//   data_i, valid_i  deserialised word and qualifier
//   detector_rst_i   restart request from the aligner
//   n_align_o        FAIL state (held until detector_rst_i)
//   locked_o         LOCKED state
//   eav_o, sav_o     valid EAV / SAV XYZ accepted (1-cycle pulses)
//   xyz_err_o        XYZ with bad protection after a preamble (pulse)
//   field_o          F bit of the last valid XYZ
//   vblank_o         V bit of the last valid XYZ
// The counters and FSM run on the decoder's registered outputs, so the whole
// timing chain is shifted by one word-cycle relative to data_i.
// ---------------------------------------------------------------------------
module sdi_trs_detector
  import sdi_trs_detector_pkg::*;
#(
  parameter int LINE_WORDS    = 1650,
  parameter int LOCK_LINES    = 3,
  parameter int MISS_LINES    = 2,
  parameter int TIMEOUT_WORDS = 3400
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [9:0] data_i,
  input  logic       valid_i,
  input  logic       detector_rst_i,
  output logic       n_align_o,
  output logic       locked_o,
  output logic       eav_o,
  output logic       sav_o,
  output logic       xyz_err_o,
  output logic       field_o,
  output logic       vblank_o
);

  localparam int CNT_W  = $clog2(TIMEOUT_WORDS + 2);
  localparam int GOOD_W = $clog2(LOCK_LINES + 1);
  localparam int MISS_W = $clog2(MISS_LINES + 1);

  logic dec_vld_s;
  logic dec_eav_s;
  logic dec_sav_s;
  logic dec_err_s;
  logic dec_f_s;
  logic dec_v_s;

  trs_state_e        state_r;
  trs_state_e        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CNT_W-1:0]  cnt_sat_s;
  logic [GOOD_W-1:0] good_r;
  logic [GOOD_W-1:0] good_next_s;
  logic [GOOD_W-1:0] good_inc_s;
  logic [MISS_W-1:0] miss_r;
  logic [MISS_W-1:0] miss_next_s;
  logic [MISS_W-1:0] miss_inc_s;
  logic              pend_r;       // miss already charged to this line
  logic              pend_next_s;
  logic              slot_s;
  logic              n_align_s;
  logic              locked_s;

  sdi_trs_detector_xyz_decode u_decode (
    .clk     (sys_clk),
    .rst     (rst),
    .clr     (detector_rst_i),
    .data    (data_i),
    .valid   (valid_i),
    .vld     (dec_vld_s),
    .is_eav  (dec_eav_s),
    .is_sav  (dec_sav_s),
    .xyz_err (dec_err_s),
    .f       (dec_f_s),
    .v       (dec_v_s)
  );

  assign cnt_inc_s  = cnt_r + CNT_W'(1);
  assign cnt_sat_s  = (cnt_r == CNT_W'(TIMEOUT_WORDS)) ? cnt_r : cnt_inc_s;
  assign good_inc_s = good_r + GOOD_W'(1);
  assign miss_inc_s = miss_r + MISS_W'(1);
  assign slot_s     = dec_vld_s && (cnt_inc_s == CNT_W'(LINE_WORDS));

  // State and counter registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= ST_SEARCH;
      cnt_r   <= '0;
      good_r  <= '0;
      miss_r  <= '0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      good_r  <= good_next_s;
      miss_r  <= miss_next_s;
      pend_r  <= pend_next_s;
    end
  end

  // Next-state and counter update for each processed word.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    good_next_s  = good_r;
    miss_next_s  = miss_r;
    pend_next_s  = pend_r;
    if (detector_rst_i) begin
      state_next_s = ST_SEARCH;
      cnt_next_s   = '0;
      good_next_s  = '0;
      miss_next_s  = '0;
      pend_next_s  = 1'b0;
    end else if (dec_vld_s && (state_r != ST_FAIL)) begin
      if (dec_eav_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_sat_s;
      end
      case (state_r)
        ST_SEARCH: begin
          if (dec_eav_s) begin
            state_next_s = ST_VERIFY;
            good_next_s  = '0;
          end else if (cnt_next_s == CNT_W'(TIMEOUT_WORDS)) begin
            state_next_s = ST_FAIL;
          end else begin
            state_next_s = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (dec_eav_s && slot_s) begin
            good_next_s = good_inc_s;
            if (good_inc_s == GOOD_W'(LOCK_LINES)) begin
              state_next_s = ST_LOCKED;
              miss_next_s  = '0;
              pend_next_s  = 1'b0;
            end else begin
              state_next_s = ST_VERIFY;
            end
          end else if (dec_eav_s) begin
            // Wrong spacing: restart verification from this EAV.
            good_next_s  = '0;
            state_next_s = ST_VERIFY;
          end else if (cnt_next_s == CNT_W'(TIMEOUT_WORDS)) begin
            state_next_s = ST_FAIL;
          end else begin
            state_next_s = ST_VERIFY;
          end
        end
        ST_LOCKED: begin
          if (slot_s) begin
            // Flywheel: the line always restarts at the expected slot.
            cnt_next_s  = '0;
            pend_next_s = 1'b0;
            if (dec_eav_s) begin
              miss_next_s = '0;
            end else if (pend_r) begin
              // An early EAV already charged this line; do not count it twice.
              miss_next_s = miss_r;
            end else begin
              miss_next_s = miss_inc_s;
            end
          end else if (dec_eav_s) begin
            // Misplaced EAV does not move the line timing.
            cnt_next_s  = cnt_sat_s;
            miss_next_s = miss_inc_s;
            pend_next_s = 1'b1;
          end else begin
            miss_next_s = miss_r;
          end
          if (miss_next_s == MISS_W'(MISS_LINES)) begin
            state_next_s = ST_FAIL;
          end else begin
            state_next_s = ST_LOCKED;
          end
        end
        default: begin
          state_next_s = state_r;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    n_align_s = 1'b0;
    locked_s  = 1'b0;
    case (state_r)
      ST_LOCKED: locked_s  = 1'b1;
      ST_FAIL:   n_align_s = 1'b1;
      default: begin
        n_align_s = 1'b0;
        locked_s  = 1'b0;
      end
    endcase
  end

  assign n_align_o = n_align_s;
  assign locked_o  = locked_s;
  assign eav_o     = dec_eav_s;
  assign sav_o     = dec_sav_s;
  assign xyz_err_o = dec_err_s;
  assign field_o   = dec_f_s;
  assign vblank_o  = dec_v_s;

endmodule

// File: tb/tb_sdi_trs_detector.sv
// ---------------------------------------------------------------------------
// tb_sdi_trs_detector
// Directed bench for sdi_trs_detector with a 16-word line, lock after 3 good
// spacings, fail after 2 misses, timeout at 40 words.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sdi_trs_detector;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [9:0] data_i;
  logic       valid_i;
  logic       detector_rst_i;
  logic       n_align_o;
  logic       locked_o;
  logic       eav_o;
  logic       sav_o;
  logic       xyz_err_o;
  logic       field_o;
  logic       vblank_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  sdi_trs_detector #(
    .LINE_WORDS    (16),
    .LOCK_LINES    (3),
    .MISS_LINES    (2),
    .TIMEOUT_WORDS (40)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .detector_rst_i (detector_rst_i),
    .n_align_o      (n_align_o),
    .locked_o       (locked_o),
    .eav_o          (eav_o),
    .sav_o          (sav_o),
    .xyz_err_o      (xyz_err_o),
    .field_o        (field_o),
    .vblank_o       (vblank_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [9:0] w);
    @(negedge sys_clk);
    data_i  = w;
    valid_i = 1'b1;
  endtask

  task automatic idle();
    @(negedge sys_clk);
    valid_i = 1'b0;
    data_i  = 10'h000;
  endtask

  task automatic settle();
    idle();
    idle();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) push(10'h155);
  endtask

  task automatic trs(input logic [9:0] xyz);
    push(10'h3FF);
    push(10'h000);
    push(10'h000);
    push(xyz);
  endtask

  // 15 words after the previous XYZ, then the next XYZ on word 16.
  task automatic line(input logic [9:0] xyz);
    fill(12);
    trs(xyz);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_n_align"}, n_align_o, 1'b0);
    check_eq({tag, "_locked"},  locked_o,  1'b0);
    check_eq({tag, "_eav"},     eav_o,     1'b0);
    check_eq({tag, "_sav"},     sav_o,     1'b0);
    check_eq({tag, "_err"},     xyz_err_o, 1'b0);
    check_eq({tag, "_field"},   field_o,   1'b0);
    check_eq({tag, "_vblank"},  vblank_o,  1'b0);
  endtask

  initial begin
    logic [9:0] r;
    rst            = 1'b1;
    data_i         = 10'h000;
    valid_i        = 1'b0;
    detector_rst_i = 1'b0;

    // Reset
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Clean lines: lock after the 4th EAV
    trs(10'h274);
    idle();
    check_eq("eav1_pulse", eav_o, 1'b1);
    idle();
    check_eq("eav1_end", eav_o, 1'b0);
    check_eq("eav1_unlocked", locked_o, 1'b0);
    line(10'h274);
    line(10'h274);
    settle();
    check_eq("lock_after3", locked_o, 1'b0);
    line(10'h274);
    idle();
    check_eq("eav4_pulse", eav_o, 1'b1);
    idle();
    check_eq("lock_after4", locked_o, 1'b1);
    check_eq("lock_n_align", n_align_o, 1'b0);

    // SAV inside a line, EAV with V=1, then EAV with F=1
    fill(4);
    trs(10'h200);
    idle();
    check_eq("sav_pulse", sav_o, 1'b1);
    check_eq("sav_no_eav", eav_o, 1'b0);
    fill(4);
    trs(10'h2D8);
    idle();
    check_eq("eav_v1_pulse", eav_o, 1'b1);
    check_eq("eav_v1_vblank", vblank_o, 1'b1);
    check_eq("eav_v1_field", field_o, 1'b0);
    line(10'h3C4);
    settle();
    check_eq("eav_f1_field", field_o, 1'b1);
    check_eq("eav_f1_locked", locked_o, 1'b1);

    // Bad XYZ in two consecutive slots
    line(10'h275);
    idle();
    check_eq("err1_pulse", xyz_err_o, 1'b1);
    check_eq("err1_no_eav", eav_o, 1'b0);
    idle();
    check_eq("err1_still_locked", locked_o, 1'b1);
    check_eq("err1_field_kept", field_o, 1'b1);
    line(10'h275);
    settle();
    check_eq("err2_n_align", n_align_o, 1'b1);
    check_eq("err2_unlocked", locked_o, 1'b0);

    // FAIL ignores data but decode still pulses
    line(10'h274);
    idle();
    check_eq("fail_eav_pulse", eav_o, 1'b1);
    idle();
    check_eq("fail_hold", n_align_o, 1'b1);

    // Restart and re-lock
    @(negedge sys_clk);
    detector_rst_i = 1'b1;
    @(negedge sys_clk);
    detector_rst_i = 1'b0;
    check_eq("restart_n_align", n_align_o, 1'b0);
    trs(10'h274);
    line(10'h274);
    line(10'h274);
    settle();
    check_eq("relock_after3", locked_o, 1'b0);
    line(10'h274);
    settle();
    check_eq("relock_after4", locked_o, 1'b1);

    // EAV one word early: one miss only, next slot EAV clears it
    fill(11);
    trs(10'h274);
    idle();
    check_eq("early_eav_pulse", eav_o, 1'b1);
    push(10'h155);
    settle();
    check_eq("early_lock_held", locked_o, 1'b1);
    line(10'h274);
    line(10'h275);
    settle();
    check_eq("miss_cleared_locked", locked_o, 1'b1);
    check_eq("miss_cleared_n_align", n_align_o, 1'b0);
    line(10'h274);
    settle();
    check_eq("post_miss_locked", locked_o, 1'b1);

    // detector_rst_i coincident with an XYZ word
    push(10'h3FF);
    push(10'h000);
    push(10'h000);
    @(negedge sys_clk);
    data_i         = 10'h274;
    valid_i        = 1'b1;
    detector_rst_i = 1'b1;
    @(negedge sys_clk);
    detector_rst_i = 1'b0;
    valid_i        = 1'b0;
    check_eq("rst_xyz_no_eav", eav_o, 1'b0);
    check_eq("rst_xyz_unlocked", locked_o, 1'b0);
    check_eq("rst_xyz_n_align", n_align_o, 1'b0);
    push(10'h274);
    idle();
    check_eq("hist_cleared", eav_o, 1'b0);

    // Reset clears F/V
    trs(10'h3C4);
    idle();
    check_eq("pre_reset_field", field_o, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset2");
    rst = 1'b0;

    // Timeout: 40 words without TRS
    for (int i = 0; i < 39; i++) begin
      r = 10'($urandom_range(32'h3FE, 32'h001));
      push(r);
    end
    settle();
    check_eq("timeout_39", n_align_o, 1'b0);
    push(10'h123);
    settle();
    check_eq("timeout_40", n_align_o, 1'b1);
    for (int i = 0; i < 5; i++) push(10'h155);
    settle();
    check_eq("timeout_hold", n_align_o, 1'b1);
    check_eq("timeout_unlocked", locked_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
